// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction opcodes, program-loader FSM states and
// the default memory geometry used by the loader.
package cpu_pkg;

   localparam int DEFAULT_DATA_W = 8;
   localparam int DEFAULT_ADDR_W = 5;

   localparam logic [2:0] HLT = 3'b000;
   localparam logic [2:0] SKZ = 3'b001;
   localparam logic [2:0] ADD = 3'b010;
   localparam logic [2:0] AND = 3'b011;
   localparam logic [2:0] XOR = 3'b100;
   localparam logic [2:0] LDA = 3'b101;
   localparam logic [2:0] STO = 3'b110;
   localparam logic [2:0] JMP = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_CHECK = 2'd2,
      ST_RUN   = 2'd3
   } loader_state_e;

   // Opcode field of a memory word at the default width.
   function automatic logic [2:0] opcode_of(input logic [DEFAULT_DATA_W-1:0] word);
      return word[DEFAULT_DATA_W-1 -: 3];
   endfunction

endpackage

// File: rtl/loader_addr_ctr.sv
// Write-address pointer that wraps modulo DEPTH, plus a payload word counter
// whose terminal-count flag marks the accept that completes the payload.
module loader_addr_ctr #(
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 2**ADDR_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              inc,
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W:0]   target,
   output logic [ADDR_W-1:0] ptr,
   output logic              last
);

   logic [ADDR_W:0]   words;
   logic [ADDR_W:0]   target_q;
   logic [ADDR_W-1:0] ptr_next;

   assign ptr_next = (ptr == ADDR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;

   // High while the word about to be accepted is the final payload word.
   assign last = ((words + 1'b1) == target_q);

   always_ff @(posedge clock) begin
      if (!reset) begin
         ptr      <= '0;
         words    <= '0;
         target_q <= '0;
      end else if (start) begin
         ptr      <= base;
         words    <= '0;
         target_q <= target;
      end else if (inc) begin
         ptr      <= ptr_next;
         words    <= words + 1'b1;
      end
   end

endmodule

// File: rtl/prog_loader.sv
// Program loader: streams words from data_in into CPU memory, then releases the core.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing checksum word before release.
module prog_loader
   import cpu_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int ADDR_W = DEFAULT_ADDR_W,
   parameter int DEPTH  = 2**ADDR_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   count,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] data_in,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              cpu_run,
   output logic              err,
   output loader_state_e     dbg_state
);

   // Handshake: a word transfers on any rising edge where in_valid and in_ready
   // are both 1. in_ready is a register driven from state alone, so the producer
   // may hold in_valid/data_in until it sees the transfer; in_valid is ignored
   // whenever in_ready is 0.

   loader_state_e     state;
   logic              load_q;
   logic              load_rise;
   logic              start;
   logic              accept;
   logic              inc;
   logic              last;
   logic [ADDR_W-1:0] ptr;

`ifdef PROG_LOADER_CHECKSUM_EN
   localparam logic CHECK_READY = 1'b1;
   logic [DATA_W-1:0] sum;
   logic [DATA_W-1:0] total;
   assign total = sum + data_in;
`else
   localparam logic CHECK_READY = 1'b0;
`endif

   // Sessions start on a rising load so a level held through RUN or a failed
   // check does not immediately relaunch.
   assign load_rise = load & ~load_q;
   assign start     = load_rise && ((state == ST_IDLE) || (state == ST_RUN));
   assign accept    = in_valid & in_ready;
   assign inc       = accept && (state == ST_LOAD);
   assign dbg_state = state;

   loader_addr_ctr #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_addr_ctr (
      .clock  (clock),
      .reset  (reset),
      .start  (start),
      .inc    (inc),
      .base   (base_addr),
      .target (count),
      .ptr    (ptr),
      .last   (last)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         state     <= ST_IDLE;
         load_q    <= 1'b0;
         in_ready  <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         cpu_run   <= 1'b0;
         err       <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
         sum       <= '0;
`endif
      end else begin
         load_q <= load;
         mem_we <= 1'b0;
         done   <= 1'b0;

         // A word accepted on the abort edge is still committed.
         if (inc) begin
            mem_we    <= 1'b1;
            mem_addr  <= ptr;
            mem_wdata <= data_in;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum       <= sum + data_in;
`endif
         end

         case (state)
            ST_IDLE, ST_RUN: begin
               if (start) begin
                  err     <= 1'b0;
                  cpu_run <= 1'b0;
                  busy    <= 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                  sum     <= '0;
`endif
                  if (count == '0) begin
                     state    <= ST_CHECK;
                     in_ready <= CHECK_READY;
                  end else begin
                     state    <= ST_LOAD;
                     in_ready <= 1'b1;
                  end
               end
            end

            ST_LOAD: begin
               if (!load) begin
                  state    <= ST_IDLE;
                  in_ready <= 1'b0;
                  busy     <= 1'b0;
                  err      <= 1'b1;
               end else if (accept && last) begin
                  state    <= ST_CHECK;
                  in_ready <= CHECK_READY;
               end
            end

            ST_CHECK: begin
               if (!load) begin
                  state    <= ST_IDLE;
                  in_ready <= 1'b0;
                  busy     <= 1'b0;
                  err      <= 1'b1;
               end else begin
`ifdef PROG_LOADER_CHECKSUM_EN
                  // The checksum word is consumed here and never reaches memory.
                  if (accept) begin
                     in_ready <= 1'b0;
                     busy     <= 1'b0;
                     if (total == '0) begin
                        state   <= ST_RUN;
                        cpu_run <= 1'b1;
                        done    <= 1'b1;
                     end else begin
                        state   <= ST_IDLE;
                        err     <= 1'b1;
                     end
                  end
`else
                  state    <= ST_RUN;
                  in_ready <= 1'b0;
                  busy     <= 1'b0;
                  cpu_run  <= 1'b1;
                  done     <= 1'b1;
`endif
               end
            end

            default: begin
               state    <= ST_IDLE;
               in_ready <= 1'b0;
               busy     <= 1'b0;
               cpu_run  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Directed-plus-random bench for prog_loader: memory writes are collected by a
// monitor and compared against addresses/data predicted from the session rules.
module tb_prog_loader;
   import cpu_pkg::*;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 32;
   localparam int W      = ADDR_W + DATA_W;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              load = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [ADDR_W:0]   count = '0;
   logic              in_valid = 1'b0;
   logic [DATA_W-1:0] data_in = '0;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              busy;
   logic              done;
   logic              cpu_run;
   logic              err;
   loader_state_e     dbg_state;

   int n_assert = 0;
   int n_fail = 0;
   int cyc = 0;
   int last_we_cyc = -1;
   int done_cyc = -1;
   int done_cnt = 0;
   int start_cyc = 0;

   logic [W-1:0]      exp_q[$];
   logic [W-1:0]      obs_q[$];
   logic [DATA_W-1:0] pay[$];

   prog_loader dut (
      .clock     (clock),
      .reset     (reset),
      .load      (load),
      .base_addr (base_addr),
      .count     (count),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_in   (data_in),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .busy      (busy),
      .done      (done),
      .cpu_run   (cpu_run),
      .err       (err),
      .dbg_state (dbg_state)
   );

   // Clock and cycle counter
   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   // Monitor: sampled on the falling edge, away from the active edge
   always @(negedge clock) begin
      if (mem_we) begin
         obs_q.push_back({mem_addr, mem_wdata});
         last_we_cyc = cyc;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: observed no end of test, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Reference model: payload word i lands at (base + i) mod DEPTH
   task automatic model_expect(input int b, input int n);
      for (int i = 0; i < n; i++)
         exp_q.push_back({ADDR_W'((b + i) % DEPTH), pay[i]});
   endtask

   function automatic logic [DATA_W-1:0] model_checksum(input int n);
      int s;
      s = 0;
      for (int i = 0; i < n; i++) s = s + int'(pay[i]);
      return DATA_W'((256 - (s % 256)) % 256);
   endfunction

   task automatic random_payload(input int n);
      pay.delete();
      for (int i = 0; i < n; i++) pay.push_back(DATA_W'($urandom_range(0, 255)));
   endtask

   task automatic start_session(input int b, input int c);
      load     = 1'b0;
      in_valid = 1'b0;
      tick();
      exp_q.delete();
      obs_q.delete();
      done_cnt    = 0;
      done_cyc    = -1;
      last_we_cyc = -1;
      base_addr   = ADDR_W'(b);
      count       = (ADDR_W+1)'(c);
      load        = 1'b1;
      tick();
      start_cyc = cyc;
      check("busy_after_start", busy, 1);
      check("err_cleared_on_start", err, 0);
      check("cpu_run_low_in_session", cpu_run, 0);
   endtask

   // Driver: present one word, optionally after random idle cycles
   task automatic send_word(input logic [DATA_W-1:0] w, input bit gaps, input bit drop_load);
      int guard;
      if (gaps) begin
         repeat ($urandom_range(0, 3)) begin
            in_valid = 1'b0;
            data_in  = DATA_W'($urandom_range(0, 255));
            tick();
         end
      end
      in_valid = 1'b1;
      data_in  = w;
      if (drop_load) load = 1'b0;
      guard = 0;
      while (!in_ready && guard < 20) begin
         tick();
         guard++;
      end
      check("in_ready_wait_bound", (guard < 20), 1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic scoreboard(input string tag);
      logic [W-1:0] e;
      logic [W-1:0] o;
      check({tag, "_write_count"}, obs_q.size(), exp_q.size());
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         check({tag, "_write_addr_data"}, o, e);
      end
   endtask

   task automatic finish_session(input string tag, input bit exp_ok);
      in_valid = 1'b0;
      repeat (3) tick();
      if (exp_ok) begin
         check({tag, "_done_pulses"}, done_cnt, 1);
         check({tag, "_cpu_run"}, cpu_run, 1);
         check({tag, "_err"}, err, 0);
         check({tag, "_state_run"}, dbg_state, ST_RUN);
      end else begin
         check({tag, "_done_pulses"}, done_cnt, 0);
         check({tag, "_cpu_run"}, cpu_run, 0);
         check({tag, "_err"}, err, 1);
         check({tag, "_state_idle"}, dbg_state, ST_IDLE);
      end
      check({tag, "_busy"}, busy, 0);
      check({tag, "_in_ready"}, in_ready, 0);
      scoreboard(tag);
   endtask

   // Full successful session using the current payload
   task automatic run_session(input string tag, input int b, input bit gaps);
      int n;
      n = pay.size();
      start_session(b, n);
      model_expect(b, n);
      for (int i = 0; i < n; i++) send_word(pay[i], gaps, 1'b0);
`ifdef PROG_LOADER_CHECKSUM_EN
      send_word(model_checksum(n), gaps, 1'b0);
`endif
      finish_session(tag, 1'b1);
`ifdef PROG_LOADER_CHECKSUM_EN
      check({tag, "_done_after_last_write"}, (done_cyc > last_we_cyc), 1);
`else
      if (n == 0) check({tag, "_done_latency"}, done_cyc, start_cyc + 1);
      else        check({tag, "_done_latency"}, done_cyc, last_we_cyc + 1);
`endif
   endtask

   initial begin
      int b;
      int n;

      // Reset state
      reset = 1'b0;
      repeat (3) tick();
      check("rst_in_ready", in_ready, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_cpu_run", cpu_run, 0);
      check("rst_err", err, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_state", dbg_state, ST_IDLE);
      reset = 1'b1;
      repeat (2) tick();

      // 22-word reference program, no gaps, base 0
      pay.delete();
      for (int i = 0; i < 22; i++)
         pay.push_back({3'(i % 8), 5'($urandom_range(0, 31))});
      run_session("ref_prog", 0, 1'b0);

      // Wrap-around from 5'h1E
      pay.delete();
      for (int i = 0; i < 4; i++) pay.push_back(8'hA0 + 8'(i));
      run_session("wrap", 30, 1'b0);

      // Random in_valid gaps on a 6-word load
      random_payload(6);
      run_session("gaps", $urandom_range(0, DEPTH - 1), 1'b1);

      // Abort after 3 of 8 words
      random_payload(8);
      b = $urandom_range(0, DEPTH - 1);
      start_session(b, 8);
      model_expect(b, 3);
      for (int i = 0; i < 3; i++) send_word(pay[i], 1'b0, 1'b0);
      load = 1'b0;
      finish_session("abort3", 1'b0);

      // count = 0
      pay.delete();
      run_session("count0", 7, 1'b0);

      // Abort on the same edge as the final accept
      random_payload(2);
      b = $urandom_range(0, DEPTH - 1);
      start_session(b, 2);
      model_expect(b, 2);
      send_word(pay[0], 1'b0, 1'b0);
      send_word(pay[1], 1'b0, 1'b1);
      finish_session("abort_final", 1'b0);

      // Reset mid-session aborts without err
      random_payload(10);
      start_session(3, 10);
      model_expect(3, 2);
      send_word(pay[0], 1'b0, 1'b0);
      send_word(pay[1], 1'b0, 1'b0);
      reset = 1'b0;
      load  = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      check("midrst_err", err, 0);
      check("midrst_busy", busy, 0);
      check("midrst_cpu_run", cpu_run, 0);
      check("midrst_in_ready", in_ready, 0);
      check("midrst_state", dbg_state, ST_IDLE);
      scoreboard("midrst");

      // Fill every word exactly once
      random_payload(DEPTH);
      run_session("full_depth", $urandom_range(0, DEPTH - 1), 1'b0);

      // A few random sessions
      for (int k = 0; k < 3; k++) begin
         n = $urandom_range(1, 12);
         random_payload(n);
         run_session("random", $urandom_range(0, DEPTH - 1), 1'b1);
      end

`ifdef PROG_LOADER_CHECKSUM_EN
      // Good and bad checksum words
      pay.delete();
      pay.push_back(8'h01);
      pay.push_back(8'h02);
      start_session(9, 2);
      model_expect(9, 2);
      send_word(pay[0], 1'b0, 1'b0);
      send_word(pay[1], 1'b0, 1'b0);
      send_word(8'hFD, 1'b0, 1'b0);
      finish_session("chk_good", 1'b1);

      start_session(9, 2);
      model_expect(9, 2);
      send_word(pay[0], 1'b0, 1'b0);
      send_word(pay[1], 1'b0, 1'b0);
      send_word(8'hFC, 1'b0, 1'b0);
      finish_session("chk_bad", 1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
